// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multicycle MIPS core.
// Define MC_PERF_CNT_EN to add cycle and retired-instruction counters.
module multicycle_control #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       timeout_err,
  output logic [3:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retired_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam int CW = (WAIT_MAX > 15) ? $clog2(WAIT_MAX + 1) : 4;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX - 1);

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] wait_cnt;
  logic          is_wait;
  logic          tmo_set;
  logic          rdy;

  // Held-off ready keeps every write strobe quiet while rst is high
  assign rdy    = mem_ready & ~rst;
  assign state  = cur;
  assign halted = (cur == S_HALT);

  always_comb begin
    nxt     = cur;
    is_wait = 1'b0;
    tmo_set = 1'b0;
    unique case (cur)
      S_FETCH: begin
        is_wait = 1'b1;
        if (rdy) nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_R):    nxt = S_EXEC;
          (opcode == OP_LW),
          (opcode == OP_SW):   nxt = S_MEMADR;
          (opcode == OP_BEQ):  nxt = S_BRANCH;
          (opcode == OP_ADDI): nxt = S_ADDIEX;
          (opcode == OP_J):    nxt = S_JUMP;
          default:             nxt = S_HALT;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        is_wait = 1'b1;
        if (rdy) nxt = S_MEMWB;
      end
      S_MEMWR: begin
        is_wait = 1'b1;
        if (rdy) nxt = S_FETCH;
      end
      S_EXEC:   nxt = S_ALUWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP:   nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_HALT;
    endcase
    if (is_wait && !rdy && wait_cnt == LIMIT) begin
      nxt     = S_HALT;
      tmo_set = 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    unique case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR,
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= S_FETCH;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (is_wait && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (tmo_set)
        timeout_err <= 1'b1;
    end
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (cur != S_HALT)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (nxt == S_FETCH && cur != S_FETCH)
        retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule
